// File: rtl/stim_rr_scheduler.sv
// Round-robin scheduler sharing one test datapath between NREQ stimulus requesters.
// Optional transaction counter output txn_count enabled by STIM_RR_SCHEDULER_STATS_EN.
module stim_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*3-1:0] req_ctl,
    output logic [NREQ-1:0]   req_ready,
    output logic [DW-1:0]     dp_data_in,
    output logic              dp_a,
    output logic              dp_b,
    output logic              dp_x,
    input  logic [DW-1:0]     dp_data_out,
    input  logic              dp_out,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_out,
    output logic              busy
`ifdef STIM_RR_SCHEDULER_STATS_EN
    ,
    output logic [15:0]       txn_count
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned NREQ_U = NREQ;

    if (LAT < 1 || NREQ < 2) begin : g_param_check
        $error("stim_rr_scheduler: requires LAT >= 1 and NREQ >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     dp_data_q, dp_data_d;
    logic [2:0]        dp_ctl_q, dp_ctl_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              rsp_out_q, rsp_out_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand_idx;
    logic [NREQ-1:0]   grant;

    // Rotating search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NREQ_U; k++) begin
            cand_idx = PW'((32'(ptr_q) + k) % NREQ_U);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == ST_IDLE && win_found && !rst) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        dp_data_d   = dp_data_q;
        dp_ctl_d    = dp_ctl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_out_d   = rsp_out_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    dp_data_d = req_data[win_idx*DW +: DW];
                    dp_ctl_d  = req_ctl[win_idx*3 +: 3];
                    ptr_d     = win_idx;
                    cnt_d     = CW'(LAT - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d         = dp_data_out;
                    rsp_out_d          = dp_out;
                    rsp_valid_d        = '0;
                    rsp_valid_d[ptr_q] = 1'b1;
                    state_d            = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PW'(NREQ - 1);
            cnt_q       <= '0;
            dp_data_q   <= '0;
            dp_ctl_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            dp_data_q   <= dp_data_d;
            dp_ctl_q    <= dp_ctl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_out_q   <= rsp_out_d;
        end
    end

`ifdef STIM_RR_SCHEDULER_STATS_EN
    logic [15:0] txn_cnt_q, txn_cnt_d;

    // Counts RESP entries, saturating at all-ones.
    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (state_q == ST_WAIT && state_d == ST_RESP && txn_cnt_q != '1) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign txn_count = txn_cnt_q;
`endif

    assign req_ready  = grant;
    assign dp_data_in = dp_data_q;
    assign dp_a       = dp_ctl_q[2];
    assign dp_b       = dp_ctl_q[1];
    assign dp_x       = dp_ctl_q[0];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_out    = rsp_out_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stim_rr_scheduler.sv
// Bench for stim_rr_scheduler: directed vector tables (LAT=2 and LAT=1 builds) plus
// randomized traffic against a transaction-level reference model.
module tb_stim_rr_scheduler;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_valid, req_ready, rsp_valid;
    logic [15:0] req_data;
    logic [11:0] req_ctl;
    logic [3:0]  dp_data_in, dp_data_out, rsp_data;
    logic        dp_a, dp_b, dp_x, dp_out, rsp_out, busy;

    logic [3:0]  v1, ready1, rspv1, dpd1, dout1, rspd1;
    logic [15:0] d1;
    logic [11:0] c1;
    logic        a1, b1, x1, out1, rspo1, busy1;
`ifdef STIM_RR_SCHEDULER_STATS_EN
    logic [15:0] txn, txn1;
`endif

    stim_rr_scheduler #(.NREQ(4), .DW(4), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ctl(req_ctl), .req_ready(req_ready),
        .dp_data_in(dp_data_in), .dp_a(dp_a), .dp_b(dp_b), .dp_x(dp_x),
        .dp_data_out(dp_data_out), .dp_out(dp_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_out(rsp_out), .busy(busy)
`ifdef STIM_RR_SCHEDULER_STATS_EN
        , .txn_count(txn)
`endif
    );

    stim_rr_scheduler #(.NREQ(4), .DW(4), .LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_data(d1), .req_ctl(c1), .req_ready(ready1),
        .dp_data_in(dpd1), .dp_a(a1), .dp_b(b1), .dp_x(x1),
        .dp_data_out(dout1), .dp_out(out1),
        .rsp_valid(rspv1), .rsp_data(rspd1), .rsp_out(rspo1), .busy(busy1)
`ifdef STIM_RR_SCHEDULER_STATS_EN
        , .txn_count(txn1)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        logic [3:0] rdy;
        logic [3:0] rspv;
        logic [3:0] rspd;
        bit         rspo;
        bit         busy;
        logic [3:0] dpd;
        logic [2:0] ctl;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [3:0] v, input logic [3:0] rdy,
                                input logic [3:0] rv, input logic [3:0] rd, input bit ro,
                                input bit b, input logic [3:0] dd, input logic [2:0] ct);
        vec_t t;
        t.rst = r; t.valid = v; t.rdy = rdy; t.rspv = rv; t.rspd = rd;
        t.rspo = ro; t.busy = b; t.dpd = dd; t.ctl = ct;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of a directed table; datapath output is a known function of the row number.
    task automatic apply_row(input vec_t v, input int r, input bit which);
        rst = v.rst;
        if (!which) begin
            req_valid   = v.valid;
            dp_data_out = 4'(r) ^ 4'h6;
            dp_out      = r[2];
        end else begin
            v1    = v.valid;
            dout1 = 4'(r) ^ 4'h9;
            out1  = r[0];
        end
        #3;
        check("req_ready", which ? ready1 : req_ready, v.rdy);
        check("rsp_valid", which ? rspv1 : rsp_valid, v.rspv);
        check("rsp_data",  which ? rspd1 : rsp_data, v.rspd);
        check("rsp_out",   which ? rspo1 : rsp_out, v.rspo);
        check("busy",      which ? busy1 : busy, v.busy);
        check("dp_data_in", which ? dpd1 : dp_data_in, v.dpd);
        check("dp_ctl",    which ? {a1, b1, x1} : {dp_a, dp_b, dp_x}, v.ctl);
        tick();
    endtask

    vec_t tab2[$];
    vec_t tab1[$];

    // Reference model state (transaction level, cycle numbers relative to phase start)
    int          free_at, rsp_cyc, cap_cyc, mptr, win;
    bit          pend;
    int          pidx;
    logic [3:0]  pdata, last_d, mdpd, exp_ready, exp_rspv, granted_prev;
    logic [2:0]  mctl;
    bit          pout, last_o;

    initial begin
        // req0..3 data 3,A,5,C; ctl 001,101,110,011
        req_data = 16'hC5A3;  req_ctl = 12'h7A9;
        d1 = 16'hC5A3;        c1 = 12'h7A9;
        req_valid = 4'hF; v1 = 4'h0;
        dp_data_out = '0; dp_out = 1'b0; dout1 = '0; out1 = 1'b0;

        // LAT=2: reset, contention 0..3,0, single req1, reset during req2 WAIT
        tab2.push_back(mk(1, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0, 3'd0));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 3'd0));
        tab2.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 3'd0));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'h0, 0, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'h0, 0, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'hF, 0, 1, 4'h2, 1, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'hF, 2, 0, 4'h2, 1, 0, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'h2, 1, 1, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'h2, 1, 1, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'hF, 0, 2, 4'hE, 0, 1, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'hF, 4, 0, 4'hE, 0, 0, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'hE, 0, 1, 4'h5, 3'd6));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'hE, 0, 1, 4'h5, 3'd6));
        tab2.push_back(mk(0, 4'hF, 0, 4, 4'hA, 1, 1, 4'h5, 3'd6));
        tab2.push_back(mk(0, 4'hF, 8, 0, 4'hA, 1, 0, 4'h5, 3'd6));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'hA, 1, 1, 4'hC, 3'd3));
        tab2.push_back(mk(0, 4'hF, 0, 0, 4'hA, 1, 1, 4'hC, 3'd3));
        tab2.push_back(mk(0, 4'hF, 0, 8, 4'h6, 0, 1, 4'hC, 3'd3));
        tab2.push_back(mk(0, 4'hF, 1, 0, 4'h6, 0, 0, 4'hC, 3'd3));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h6, 0, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h6, 0, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'h0, 0, 1, 4'h2, 1, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'h2, 2, 0, 4'h2, 1, 0, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h2, 1, 1, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h2, 1, 1, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'h0, 0, 2, 4'hE, 0, 1, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'h4, 4, 0, 4'hE, 0, 0, 4'hA, 3'd5));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'hE, 0, 1, 4'h5, 3'd6));
        tab2.push_back(mk(1, 4'h0, 0, 0, 4'hE, 0, 1, 4'h5, 3'd6));
        tab2.push_back(mk(0, 4'hF, 1, 0, 4'h0, 0, 0, 4'h0, 3'd0));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'h0, 0, 1, 4'h9, 1, 1, 4'h3, 3'd1));
        tab2.push_back(mk(0, 4'h0, 0, 0, 4'h9, 1, 0, 4'h3, 3'd1));

        // LAT=1: single request then back-to-back accepts 3 cycles apart
        tab1.push_back(mk(0, 4'h2, 2, 0, 4'h0, 0, 0, 4'h0, 3'd0));
        tab1.push_back(mk(0, 4'hF, 0, 0, 4'h0, 0, 1, 4'hA, 3'd5));
        tab1.push_back(mk(0, 4'hF, 0, 2, 4'h8, 1, 1, 4'hA, 3'd5));
        tab1.push_back(mk(0, 4'hF, 4, 0, 4'h8, 1, 0, 4'hA, 3'd5));
        tab1.push_back(mk(0, 4'hF, 0, 0, 4'h8, 1, 1, 4'h5, 3'd6));
        tab1.push_back(mk(0, 4'hF, 0, 4, 4'hD, 0, 1, 4'h5, 3'd6));
        tab1.push_back(mk(0, 4'hF, 8, 0, 4'hD, 0, 0, 4'h5, 3'd6));
        tab1.push_back(mk(0, 4'h0, 0, 0, 4'hD, 0, 1, 4'hC, 3'd3));

        rst = 1'b1;
        tick();
        foreach (tab2[i]) apply_row(tab2[i], i, 1'b0);

        // Randomized traffic against the transaction-level model
        rst = 1'b1; req_valid = '0;
        tick();
        free_at = 0; mptr = 3; pend = 0; pidx = 0; rsp_cyc = 0; cap_cyc = 0;
        pdata = '0; pout = 0; last_d = '0; last_o = 0; mdpd = '0; mctl = '0;
        granted_prev = '0;
        for (int k = 0; k < 2000; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 4; i++) begin
                if (granted_prev[i] || !req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    if (req_valid[i]) begin
                        req_data[i*4 +: 4] = 4'($urandom);
                        req_ctl[i*3 +: 3]  = 3'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            dp_data_out = 4'($urandom);
            dp_out      = 1'($urandom);

            win = -1;
            for (int off = 1; off <= 4; off++) begin
                if (win < 0 && req_valid[(mptr + off) % 4]) win = (mptr + off) % 4;
            end
            exp_ready = (!rst && k >= free_at && win >= 0) ? 4'(1 << win) : 4'h0;
            if (pend && k == cap_cyc) begin
                pdata = dp_data_out;
                pout  = dp_out;
            end
            exp_rspv = '0;
            if (pend && k == rsp_cyc) begin
                exp_rspv = 4'(1 << pidx);
                last_d = pdata;
                last_o = pout;
                pend = 0;
            end
            #3;
            check("rnd_req_ready", req_ready, exp_ready);
            check("rnd_rsp_valid", rsp_valid, exp_rspv);
            check("rnd_rsp_data", rsp_data, last_d);
            check("rnd_rsp_out", rsp_out, last_o);
            check("rnd_busy", busy, k < free_at);
            check("rnd_dp_data_in", dp_data_in, mdpd);
            check("rnd_dp_ctl", {dp_a, dp_b, dp_x}, mctl);
            granted_prev = exp_ready;
            if (rst) begin
                pend = 0; free_at = k + 1; mptr = 3;
                mdpd = '0; mctl = '0; last_d = '0; last_o = 0;
            end else if (exp_ready != 0) begin
                mptr = win; pidx = win; pend = 1;
                mdpd = req_data[win*4 +: 4];
                mctl = req_ctl[win*3 +: 3];
                cap_cyc = k + 2;
                rsp_cyc = k + 3;
                free_at = k + 4;
            end
            tick();
        end

        rst = 1'b1; req_valid = '0; v1 = '0;
        req_data = 16'hC5A3; req_ctl = 12'h7A9;
        tick();
        foreach (tab1[i]) apply_row(tab1[i], i, 1'b1);

`ifdef STIM_RR_SCHEDULER_STATS_EN
        rst = 1'b1; v1 = '0; req_valid = '0;
        tick();
        rst = 1'b0; req_valid = 4'hF;
        repeat (80) tick();
        req_valid = '0;
        repeat (3) tick();
        check("txn_count_20", txn, 16'd20);
        force dut.txn_cnt_q = 16'hFFFE;
        tick();
        release dut.txn_cnt_q;
        req_valid = 4'hF;
        repeat (12) tick();
        req_valid = '0;
        repeat (3) tick();
        check("txn_count_sat", txn, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
